imem_arbiter: RTL

- Memory-controller side of the instruction-fetch interface: the responder for the per-CPU icache iREN/iaddr/iwait/iload handshake.
- Arbitrates instruction reads from CPUS icaches round-robin and issues one RAM read at a time.
- Returns the fetched word to the winning cache.
- Yields to the data side: never starts a new fetch while dbusy is high.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/imem_arbiter_rr_pick.sv | 29 ++
 rtl/imem_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-controller side of the CPU interfaces:
// the RAM status encoding, the word type and the instruction-fetch arbiter states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } imem_arb_state_t;

endpackage

// File: rtl/imem_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set req bit scanning upward from
// last+1 with wrap-around wins.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Walk from the farthest offset down to the nearest, so the nearest
  // requester after last is the one that sticks.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last) + off) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-fetch arbiter: round-robin across icaches, one RAM read at a time,
// and never starts a new fetch while the data side is busy.
module imem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [CPUS-1:0]            iREN,
  input  logic [CPUS-1:0][WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]            iwait,
  output logic [CPUS-1:0][WORD_W-1:0] iload,
  input  logic                       dbusy,
  output logic                       ramREN,
  output logic [WORD_W-1:0]          ramaddr,
  input  logic [WORD_W-1:0]          ramload,
  input  logic [1:0]                 ramstate,
  output imem_arb_state_t            dbg_state
);

  localparam int CPUID_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  imem_arb_state_t             state_q, state_d;
  logic [CPUID_W-1:0]          cpu_q, cpu_d;
  logic [CPUID_W-1:0]          last_q, last_d;
  word_t                       addr_q, addr_d;
  logic [CPUS-1:0][WORD_W-1:0] iload_q, iload_d;

  logic               pick_valid;
  logic [CPUID_W-1:0] pick_idx;

  rr_pick #(.N(CPUS), .IDX_W(CPUID_W)) u_rr_pick (
    .req       (iREN),
    .last      (last_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cpu_q   <= '0;
      last_q  <= CPUID_W'(CPUS - 1);
      addr_q  <= '0;
      iload_q <= '0;
    end else begin
      state_q <= state_d;
      cpu_q   <= cpu_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      iload_q <= iload_d;
    end
  end

  // A dropped iREN during REQ is a cache abort and beats a same-cycle ACCESS;
  // ERROR simply keeps the read asserted so the RAM retries it.
  always_comb begin
    state_d = state_q;
    cpu_d   = cpu_q;
    last_d  = last_q;
    addr_d  = addr_q;
    iload_d = iload_q;
    case (state_q)
      IDLE: begin
        if (!dbusy && pick_valid) begin
          cpu_d   = pick_idx;
          addr_d  = iaddr[pick_idx];
          state_d = REQ;
        end
      end
      REQ: begin
        if (!iREN[cpu_q]) begin
          state_d = IDLE;
        end else if (ramstate_t'(ramstate) == ACCESS) begin
          iload_d[cpu_q] = ramload;
          state_d        = DONE;
        end
      end
      DONE: begin
        last_d  = cpu_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < CPUS; k++) begin
      iwait[k] = !((state_q == DONE) && (cpu_q == CPUID_W'(k)));
    end
  end

  assign ramREN    = (state_q == REQ);
  assign ramaddr   = addr_q;
  assign iload     = iload_q;
  assign dbg_state = state_q;

endmodule
